reg_serializer: RTL and testbench
=================================

Name: reg_serializer

Overview:
- Parallel-in, serial-out reader for an 8-bit storage register.
- Accepts a stored word over a valid/ready handshake and shifts it out one bit at a time, each bit held for a fixed number of clocks.
- Drives a frame envelope, a per-bit strobe and an end-of-word pulse.
- Sits between the enable-loaded data register and a serial link or debug readback pin.

Parameters:
- WIDTH, 8: word width in bits; legal values are 2 or more.
- DIV, 4: clocks per serial bit; legal values are 1 or more.
- MSB_FIRST, 1: 1 shifts from bit WIDTH-1 down to bit 0; 0 shifts from bit 0 up.

Ports:
- i_clk, input, 1: rising-edge clock.
- i_rst_n, input, 1: reset, asynchronous, active-low.
- i_valid, input, 1: i_data holds a word to serialize.
- i_data, input, WIDTH: parallel word; sampled only on the accept edge.
- o_ready, output, 1: block can accept a word.
- o_sdata, output, 1: serial data bit.
- o_sframe, output, 1: high while a bit of the word is being driven on o_sdata.
- o_sbit_stb, output, 1: one-cycle pulse in the first cycle of each bit.
- o_done, output, 1: one-cycle pulse after the last bit has completed.

Behaviour:
- All outputs are registered.
- Reset values: o_ready=1, o_sdata=0, o_sframe=0, o_sbit_stb=0, o_done=0, state=IDLE, counters=0, shift register=0.
- Reset assertion mid-word aborts the word at once (asynchronously). No o_done pulse is produced for the aborted word.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - o_ready=1.
  - Accept occurs on a posedge with i_valid=1 and o_ready=1.
  - On accept: load i_data into the shift register, clear the bit counter and the div counter, and go to SHIFT.
  - With no accept, hold all outputs at their idle values.
- SHIFT:
  - o_ready=0, o_sframe=1.
  - o_sdata carries the current bit: MSB first when MSB_FIRST=1, LSB first otherwise.
  - The first bit appears in the cycle after the accept edge (latency 1).
  - Each bit is held for exactly DIV cycles.
  - o_sbit_stb=1 in the first of those DIV cycles.
  - The div counter counts 0..DIV-1. On wrap, the shift register advances one bit and the bit counter increments.
  - After WIDTH bits (WIDTH*DIV cycles in SHIFT), go to DONE.
- DONE:
  - Lasts one cycle: o_done=1, o_sframe=0, o_sdata=0, o_ready=0.
  - Then go to IDLE. o_ready=1 in the following cycle.
- Throughput: back-to-back accepts are WIDTH*DIV+2 cycles apart. With defaults this is 34 cycles.
- i_valid while busy (SHIFT or DONE) is ignored. The word is not queued. The source must hold i_valid until it sees o_ready.
- Changes to i_data after the accept edge have no effect on the word being shifted.
- DIV=1: o_sbit_stb is high for every SHIFT cycle, and the bit changes every cycle.
- Counter widths: bit counter is clog2(WIDTH+1) bits; div counter is max(1, clog2(DIV)) bits. Neither counter wraps past its terminal value.
- o_sdata, o_sbit_stb and o_sframe are never X outside reset.

Test Plan:
- Reset, then idle for 5 cycles -> o_ready=1 and all other outputs 0 throughout. o_done never pulses.
- Defaults, accept i_data=8'hA5 -> starting 1 cycle after accept, o_sdata=1,0,1,0,0,1,0,1, each bit held 4 cycles.
  - o_sbit_stb pulses 8 times, 4 cycles apart.
  - o_sframe is high for 32 cycles.
  - o_done pulses in cycle 33 after accept, and o_ready=1 in cycle 34.
- MSB_FIRST=0, DIV=1, accept 8'h01 -> o_sdata=1,0,0,0,0,0,0,0 on consecutive cycles, with o_sbit_stb high for all 8 cycles.
- Accept 8'hFF; during SHIFT drive i_valid=1 with i_data=8'h00 -> the serial stream stays all ones and o_ready stays 0.
  - After o_done, 8'h00 is accepted and shifted as zeros.
- Assert i_rst_n=0 at the 4th bit of 8'h3C -> o_sframe=0 and o_ready=1 right after reset, with no o_done pulse.
  - A fresh accept of 8'hC3 after reset serializes correctly.
- Hold i_valid=1 continuously with alternating words 8'h55 and 8'hAA -> accepts occur exactly 34 cycles apart, and each word serializes without corruption.

Source files
------------

// File: rtl/reg_serializer.sv
// reg_serializer: accepts a word over valid/ready and shifts it out serially, DIV clocks per bit,
// with frame envelope, per-bit strobe and end-of-word pulse; every output is a flop.
module reg_serializer #(
    parameter int WIDTH     = 8,
    parameter int DIV       = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_valid,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_ready,
    output logic             o_sdata,
    output logic             o_sframe,
    output logic             o_sbit_stb,
    output logic             o_done
);
    localparam int BW = $clog2(WIDTH + 1);
    localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int SB = MSB_FIRST ? WIDTH - 1 : 0;

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

    state_t           r_state, w_state_nx;
    logic [WIDTH-1:0] r_shift, w_shift_nx;
    logic [BW-1:0]    r_bit, w_bit_nx;
    logic [DW-1:0]    r_div, w_div_nx;
    logic             w_wrap;

    assign w_wrap = r_div == DW'(DIV - 1);

    always_comb begin
        w_state_nx = r_state;
        w_shift_nx = r_shift;
        w_bit_nx   = r_bit;
        w_div_nx   = r_div;
        case (r_state)
            S_IDLE: if (i_valid) begin
                w_state_nx = S_SHIFT;
                w_shift_nx = i_data;
                w_bit_nx   = '0;
                w_div_nx   = '0;
            end
            S_SHIFT: begin
                w_div_nx = w_wrap ? '0 : r_div + 1'b1;
                // zeros shift in, so the register is already clear when the word ends
                if (w_wrap) begin
                    w_bit_nx   = r_bit + 1'b1;
                    w_shift_nx = MSB_FIRST ? {r_shift[WIDTH-2:0], 1'b0} : {1'b0, r_shift[WIDTH-1:1]};
                    if (r_bit == BW'(WIDTH - 1)) w_state_nx = S_DONE;
                end
            end
            S_DONE: begin
                w_state_nx = S_IDLE;
                w_bit_nx   = '0;
                w_div_nx   = '0;
            end
            default: w_state_nx = S_IDLE;
        endcase
    end

    // outputs are registered from the next-state values so they align with the state they describe
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= S_IDLE;
            r_shift    <= '0;
            r_bit      <= '0;
            r_div      <= '0;
            o_ready    <= 1'b1;
            o_sdata    <= 1'b0;
            o_sframe   <= 1'b0;
            o_sbit_stb <= 1'b0;
            o_done     <= 1'b0;
        end else begin
            r_state    <= w_state_nx;
            r_shift    <= w_shift_nx;
            r_bit      <= w_bit_nx;
            r_div      <= w_div_nx;
            o_ready    <= w_state_nx == S_IDLE;
            o_sdata    <= (w_state_nx == S_SHIFT) && w_shift_nx[SB];
            o_sframe   <= w_state_nx == S_SHIFT;
            o_sbit_stb <= (w_state_nx == S_SHIFT) && (w_div_nx == '0);
            o_done     <= w_state_nx == S_DONE;
        end
    end
endmodule

// File: tb/tb_reg_serializer.sv
// tb_reg_serializer: randomized and directed checks of reg_serializer against a per-cycle frame model,
// using a default instance and an LSB-first DIV=1 instance.
module tb_reg_serializer;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       valid0 = 1'b0, valid1 = 1'b0;
    logic [7:0] data0 = '0, data1 = '0;
    logic       ready0, sdata0, sframe0, stb0, done0;
    logic       ready1, sdata1, sframe1, stb1, done1;
    logic [4:0] obs0, obs1, exp;
    int         vecs = 0;
    int         errs = 0;

    always #5 clk = ~clk;

    reg_serializer u_dut0 (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid0), .i_data(data0),
        .o_ready(ready0), .o_sdata(sdata0), .o_sframe(sframe0), .o_sbit_stb(stb0), .o_done(done0)
    );

    reg_serializer #(.WIDTH(8), .DIV(1), .MSB_FIRST(1'b0)) u_dut1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid1), .i_data(data1),
        .o_ready(ready1), .o_sdata(sdata1), .o_sframe(sframe1), .o_sbit_stb(stb1), .o_done(done1)
    );

    assign obs0 = {ready0, sdata0, sframe0, stb0, done0};
    assign obs1 = {ready1, sdata1, sframe1, stb1, done1};

    // expected {ready, sdata, sframe, stb, done} in cycle k after the accept edge
    function automatic logic [4:0] model(input logic [7:0] w, input int k, input int div, input bit msb);
        int idx;
        if (k <= 8 * div) begin
            idx = (k - 1) / div;
            return {1'b0, msb ? w[7 - idx] : w[idx], 1'b1, (k - 1) % div == 0, 1'b0};
        end
        if (k == 8 * div + 1) return 5'b00001;
        return 5'b10000;
    endfunction

    task automatic send0(input logic [7:0] w);
        valid0 = 1'b1;
        data0  = w;
        @(posedge clk);
        #1 valid0 = 1'b0;
        data0 = 8'($urandom);
    endtask

    task automatic send1(input logic [7:0] w);
        valid1 = 1'b1;
        data1  = w;
        @(posedge clk);
        #1 valid1 = 1'b0;
        data1 = 8'($urandom);
    endtask

    task automatic test_reset;
        repeat (2) @(negedge clk);
        vecs++;
        if ({obs0, obs1} !== {5'b10000, 5'b10000}) begin
            errs++;
            $display("FAIL reset_hold got %b %b exp 10000 10000", obs0, obs1);
        end
        rst_n = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            vecs++;
            if ({obs0, obs1} !== {5'b10000, 5'b10000}) begin
                errs++;
                $display("FAIL idle c%0d got %b %b exp 10000 10000", k, obs0, obs1);
            end
        end
    endtask

    task automatic test_a5;
        send0(8'hA5);
        for (int k = 1; k <= 34; k++) begin
            @(negedge clk);
            exp = model(8'hA5, k, 4, 1'b1);
            vecs++;
            if (obs0 !== exp) begin
                errs++;
                $display("FAIL a5 c%0d got %b exp %b", k, obs0, exp);
            end
        end
    endtask

    task automatic test_lsb_div1;
        send1(8'h01);
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            exp = model(8'h01, k, 1, 1'b0);
            vecs++;
            if (obs1 !== exp) begin
                errs++;
                $display("FAIL lsb_div1 c%0d got %b exp %b", k, obs1, exp);
            end
        end
    endtask

    task automatic test_busy_ignored;
        send0(8'hFF);
        valid0 = 1'b1;
        data0  = 8'h00;
        for (int k = 1; k <= 34; k++) begin
            @(negedge clk);
            exp = model(8'hFF, k, 4, 1'b1);
            vecs++;
            if (obs0 !== exp) begin
                errs++;
                $display("FAIL busy_ff c%0d got %b exp %b", k, obs0, exp);
            end
        end
        @(posedge clk);
        #1 valid0 = 1'b0;
        for (int k = 1; k <= 34; k++) begin
            @(negedge clk);
            exp = model(8'h00, k, 4, 1'b1);
            vecs++;
            if (obs0 !== exp) begin
                errs++;
                $display("FAIL busy_00 c%0d got %b exp %b", k, obs0, exp);
            end
        end
    endtask

    task automatic test_reset_abort;
        send0(8'h3C);
        repeat (13) @(negedge clk);
        rst_n = 1'b0;
        #1;
        vecs++;
        if (obs0 !== 5'b10000) begin
            errs++;
            $display("FAIL abort_async got %b exp 10000", obs0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            vecs++;
            if (obs0 !== 5'b10000) begin
                errs++;
                $display("FAIL abort_idle c%0d got %b exp 10000", k, obs0);
            end
        end
        send0(8'hC3);
        for (int k = 1; k <= 34; k++) begin
            @(negedge clk);
            exp = model(8'hC3, k, 4, 1'b1);
            vecs++;
            if (obs0 !== exp) begin
                errs++;
                $display("FAIL abort_c3 c%0d got %b exp %b", k, obs0, exp);
            end
        end
    endtask

    task automatic test_back_to_back;
        logic [7:0] w;
        valid0 = 1'b1;
        for (int n = 0; n < 4; n++) begin
            w = n[0] ? 8'hAA : 8'h55;
            data0 = w;
            @(posedge clk);
            #1 data0 = ~w;
            for (int k = 1; k <= 34; k++) begin
                @(negedge clk);
                exp = model(w, k, 4, 1'b1);
                vecs++;
                if (obs0 !== exp) begin
                    errs++;
                    $display("FAIL b2b w%0d c%0d got %b exp %b", n, k, obs0, exp);
                end
            end
        end
        @(posedge clk);
        #1 valid0 = 1'b0;
        repeat (34) @(negedge clk);
    endtask

    task automatic test_random;
        logic [7:0] w0, w1;
        for (int n = 0; n < 6; n++) begin
            w0 = 8'($urandom);
            w1 = 8'($urandom);
            repeat ($urandom_range(0, 3)) @(negedge clk);
            send0(w0);
            for (int k = 1; k <= 34; k++) begin
                @(negedge clk);
                data0 = 8'($urandom);
                exp = model(w0, k, 4, 1'b1);
                vecs++;
                if (obs0 !== exp) begin
                    errs++;
                    $display("FAIL rand0 %h c%0d got %b exp %b", w0, k, obs0, exp);
                end
            end
            send1(w1);
            for (int k = 1; k <= 10; k++) begin
                @(negedge clk);
                data1 = 8'($urandom);
                exp = model(w1, k, 1, 1'b0);
                vecs++;
                if (obs1 !== exp) begin
                    errs++;
                    $display("FAIL rand1 %h c%0d got %b exp %b", w1, k, obs1, exp);
                end
            end
        end
    endtask

    initial begin
        test_reset;
        test_a5;
        test_lsb_div1;
        test_busy_ignored;
        test_reset_abort;
        test_back_to_back;
        test_random;
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
